sqrt_request_master: RTL and testbench
======================================

# sqrt_request_master

Initiator for the square-root engine's START/DONE/AVAILABLE handshake. Operands arrive on a valid/ready stream and are buffered in a small FIFO. Each operand is issued to the engine, and the 64-bit result is returned on a valid/ready output stream. The block sits between the datapath producer and the Newton square-root engine, so upstream logic never handles the engine handshake directly.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 1023: max cycles in ISSUE+WAIT_DONE before abort; used only with the timeout feature.
- clk  in  1  clock; all logic on posedge.
- rstn  in  1  reset; asynchronous, active-low.
- op_valid  in  1  operand offered.
- op_ready  out  1  FIFO not full; combinational from occupancy.
- op_data  in  32  unsigned operand.
- res_valid  out  1  result held for consumer.
- res_ready  in  1  consumer accepts result.
- res_data  out  64  engine result, passed through unmodified.
- eng_in  out  32  operand to engine; registered.
- eng_start  out  1  engine START; registered.
- eng_available  in  1  engine AVAILABLE.
- eng_done  in  1  engine DONE.
- eng_out  in  64  engine result.
- busy  out  1  asserted when the FSM is not in IDLE, the FIFO is non-empty, or res_valid is high.
- err_timeout  out  1  sticky abort flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE, RELEASE.
- IDLE
  - Leaves when the FIFO is non-empty, eng_available=1 and eng_done=0.
  - Pops the head into eng_in, sets eng_start=1, goes to ISSUE.
- ISSUE
  - eng_start held at 1.
  - eng_available=0 means the engine has accepted the operand: go to WAIT_DONE.
- WAIT_DONE
  - Leaves when eng_done=1 and the result slot is free (res_valid=0, or res_valid&res_ready this cycle).
  - Captures res_data<=eng_out, sets res_valid<=1 and eng_start<=0, goes to RELEASE.
  - While the slot is full, eng_start stays high. The engine holds DONE in this case, which gives natural backpressure.
- RELEASE
  - Leaves when eng_done=0 and eng_available=1: go to IDLE.
- Result slot
  - res_valid clears on res_valid&res_ready unless it is reloaded in the same cycle.
  - res_data is stable while res_valid=1.
- FIFO
  - Push on op_valid&op_ready; pop on the IDLE→ISSUE transition.
  - Push and pop in the same cycle are allowed when not full. When full, op_ready=0; there is no bypass.
  - Occupancy counter is $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- Ordering: results leave in operand order, exactly one result per accepted operand.

## Timing
- Reset values
  - eng_start=0, eng_in=0, res_valid=0, res_data=0, err_timeout=0.
  - FIFO empty, so op_ready=1 and busy=0. State=IDLE.
- Reset is effective asynchronously mid-operation. Any in-flight operand is lost.
- Operand accept to eng_start high: 1 cycle after push at the earliest (push at edge N, IDLE pop at edge N+1).
- DONE seen to res_valid high: 1 edge. eng_start falls on the same edge.
- Minimum gap between consecutive eng_start rising edges: RELEASE + IDLE, i.e. ≥2 cycles after DONE deasserts.
- Glitch-free outputs: only op_ready and busy are combinational.

## Configuration
- SQRT_MASTER_TIMEOUT_EN defined:
  - An 11-bit+ cycle counter runs in ISSUE and WAIT_DONE and clears on entry to ISSUE.
  - When it reaches TIMEOUT_CYCLES: set err_timeout (sticky until reset), drop eng_start, discard the operand (no result produced), go to RELEASE.
- SQRT_MASTER_TIMEOUT_EN undefined:
  - No counter; the block waits indefinitely.
  - err_timeout is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Shared package sqrt_pkg holds:
  - SQRT_IN_W=32 and SQRT_OUT_W=64.
  - The sqrt_master_state_t enum {IDLE, ISSUE, WAIT_DONE, RELEASE}.
  - The default timeout constant.
- One sub-module, sqrt_req_fifo: parameterised DEPTH×32 synchronous FIFO with full/empty/count, async active-low reset.
- Everything else (FSM, result slot, timeout) lives in sqrt_request_master.

## Test plan
The bench uses a behavioural engine model that follows the START/DONE/AVAILABLE protocol with configurable latency and returns a fixed-point sqrt.

- Single op: op_data=16, engine latency 20, res_ready=1 → one res_valid pulse with res_data=64'h0000_0000_0004_0000; busy returns to 0.
- Burst: 6 operands (1,4,9,16,25,36) pushed back-to-back with DEPTH=4 → op_ready low while full; 6 results in order 1..6 (16.16 fixed point); no eng_start while eng_done=1.
- Backpressure: res_ready=0 for 50 cycles after the first result → eng_start stays high and the second result is not captured until the first is accepted; no result is lost or duplicated.
- Reset mid-op: rstn low during WAIT_DONE → eng_start, res_valid and busy are 0 immediately; after release, a new op_data=100 returns 10.0 correctly.
- Timeout (with SQRT_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=15): engine never asserts DONE → err_timeout=1 at cycle 15 of ISSUE+WAIT_DONE, eng_start=0, no res_valid; the next operand still completes.
- Same-cycle push/pop: FIFO holding 1 entry, IDLE pops while op_valid=1 → count stays 1; data order preserved.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared widths, FSM state type and default timeout for the sqrt request master.
package sqrt_pkg;
  localparam int SQRT_IN_W = 32;
  localparam int SQRT_OUT_W = 64;
  localparam int SQRT_TIMEOUT_DEFAULT = 1023;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RELEASE} sqrt_master_state_t;
endpackage

// File: rtl/sqrt_req_fifo.sv
// sqrt_req_fifo: DEPTH x 32 synchronous operand FIFO with full/empty/count.
module sqrt_req_fifo
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [SQRT_IN_W-1:0]   wdata,
  output logic [SQRT_IN_W-1:0]   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [SQRT_IN_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rdata = mem[rptr];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  // storage carries no reset; occupancy alone defines validity
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/sqrt_request_master.sv
// sqrt_request_master: buffers operands and drives the sqrt engine START/DONE/AVAILABLE handshake.
// Optional abort timer enabled by defining SQRT_MASTER_TIMEOUT_EN.
module sqrt_request_master
  import sqrt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = SQRT_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [SQRT_IN_W-1:0]  op_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [SQRT_OUT_W-1:0] res_data,
  output logic [SQRT_IN_W-1:0]  eng_in,
  output logic                  eng_start,
  input  logic                  eng_available,
  input  logic                  eng_done,
  input  logic [SQRT_OUT_W-1:0] eng_out,
  output logic                  busy,
  output logic                  err_timeout
);
  sqrt_master_state_t state, nxt;
  logic [SQRT_IN_W-1:0] fifo_rdata;
  logic fifo_full, fifo_empty, pop, capture, abort;
  logic [$clog2(DEPTH):0] fifo_count;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sqrt_request_master: invalid DEPTH or TIMEOUT_CYCLES");
  end
  sqrt_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rstn(rstn), .push(op_valid), .pop(pop), .wdata(op_data),
    .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  assign op_ready = !fifo_full;
  assign busy = state != IDLE || fifo_count != '0 || res_valid;
  assign pop = state == IDLE && !fifo_empty && eng_available && !eng_done;
  assign capture = state == WAIT_DONE && eng_done && (!res_valid || res_ready);
`ifdef SQRT_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1) > 11 ? $clog2(TIMEOUT_CYCLES + 1) : 11;
  logic [TW-1:0] tmo_cnt;
  logic in_flight;
  assign in_flight = state == ISSUE || state == WAIT_DONE;
  // the cycle on which the count reads TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th in flight
  assign abort = in_flight && !capture && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tmo_cnt <= '0;
      err_timeout <= 1'b0;
    end else begin
      tmo_cnt <= pop ? '0 : in_flight ? tmo_cnt + 1'b1 : tmo_cnt;
      err_timeout <= err_timeout || abort;
    end
`else
  assign abort = 1'b0;
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = pop ? ISSUE : IDLE;
      ISSUE:     nxt = abort ? RELEASE : !eng_available ? WAIT_DONE : ISSUE;
      WAIT_DONE: nxt = (capture || abort) ? RELEASE : WAIT_DONE;
      default:   nxt = (!eng_done && eng_available) ? IDLE : RELEASE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      eng_in <= '0;
      eng_start <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
    end else begin
      if (pop) eng_in <= fifo_rdata;
      eng_start <= pop ? 1'b1 : (capture || abort) ? 1'b0 : eng_start;
      if (capture) res_data <= eng_out;
      res_valid <= capture ? 1'b1 : res_ready ? 1'b0 : res_valid;
    end
endmodule

// File: tb/tb_sqrt_request_master.sv
// tb_sqrt_request_master: scoreboard bench with a behavioural sqrt engine and fixed-point reference.
module tb_sqrt_request_master;
  logic clk = 1'b0, rstn = 1'b0;
  logic op_valid, op_ready, res_valid, res_ready, eng_start, eng_available, eng_done, busy, err_timeout;
  logic [31:0] op_data, eng_in, e_op;
  logic [63:0] res_data, eng_out;
  int checks = 0, fails = 0, nres = 0, lat = 20, e_cnt, n0;
  bit lat_rand = 0, never_done = 0, rr_rand = 0, saw_full = 0, e_busy;
  logic rr_fixed = 1'b1;
  logic [63:0] q[$];
`ifdef SQRT_MASTER_TIMEOUT_EN
  localparam int TMO = 15;
`else
  localparam int TMO = 1023;
`endif
  always #5 clk = ~clk;
  sqrt_request_master #(.DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .eng_in(eng_in),
    .eng_start(eng_start), .eng_available(eng_available), .eng_done(eng_done), .eng_out(eng_out),
    .busy(busy), .err_timeout(err_timeout)
  );
  // 16.16 fixed-point square root: largest r with r*r <= x*2^32
  function automatic logic [63:0] fx_sqrt(input logic [31:0] x);
    logic [63:0] v, r, t;
    v = {x, 32'd0};
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // behavioural engine: accept on START, compute after latency, hold DONE until START drops
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      eng_available <= 1'b1; eng_done <= 1'b0; eng_out <= '0; e_busy <= 0; e_cnt <= 0; e_op <= '0;
    end else if (!e_busy) begin
      if (eng_start && eng_available) begin
        e_busy <= 1; eng_available <= 1'b0; e_op <= eng_in;
        e_cnt <= lat_rand ? int'($urandom_range(0, 6)) : lat;
      end
    end else if (!eng_done) begin
      if (!eng_start) begin
        e_busy <= 0; eng_available <= 1'b1;
      end else if (!never_done) begin
        if (e_cnt == 0) begin eng_done <= 1'b1; eng_out <= fx_sqrt(e_op); end
        else e_cnt <= e_cnt - 1;
      end
    end else if (!eng_start) begin
      eng_done <= 1'b0; e_busy <= 0; eng_available <= 1'b1;
    end
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
    end
  end
  // monitor: pops the scoreboard on every result handshake
  initial begin
    logic hold, ps;
    logic [63:0] hd;
    hold = 0; ps = 0; hd = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold = 0; ps = 0;
      end else begin
        if (!op_ready) saw_full = 1;
        if (hold && res_valid) chk("res_hold", res_data, hd);
        if (eng_start && !ps) chk("start_while_done", eng_done, 0);
        if (res_valid && res_ready) begin
          nres++;
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL extra_result: got %h expected none", res_data);
          end else chk("result", res_data, q.pop_front());
        end
        hold = res_valid && !res_ready; hd = res_data; ps = eng_start;
      end
    end
  end
  task automatic push_op(input logic [31:0] x, input bit has_exp, input logic [63:0] exp);
    int n = 0;
    op_valid = 1'b1; op_data = x;
    do begin @(negedge clk); n++; end while (!op_ready && n < 2000);
    chk("op_accept", op_ready, 1);
    if (op_ready && has_exp) q.push_back(exp);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || q.size() != 0) && n < 5000);
    chk("drain_busy", busy, 0);
    chk("drain_queue", q.size(), 0);
  endtask
  task automatic align();
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    op_valid = 1'b0; op_data = '0;
    #12;
    chk("rst_op_ready", op_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_in", eng_in, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err_timeout, 0);
    @(negedge clk) rstn = 1'b1;
    align(); lat = 20; n0 = nres;
    push_op(32'd16, 1, 64'h0000_0000_0004_0000);
    wait_idle();
    chk("single_count", nres - n0, 1);
    align(); saw_full = 0; n0 = nres;
    for (int i = 1; i <= 6; i++) push_op(32'(i * i), 1, 64'(i) << 16);
    chk("burst_full_seen", saw_full, 1);
    wait_idle();
    chk("burst_count", nres - n0, 6);
    lat = 5; rr_fixed = 1'b0; align(); n0 = nres;
    push_op(32'd49, 1, 64'd7 << 16);
    push_op(32'd64, 1, 64'd8 << 16);
    n = 0;
    do begin @(negedge clk); n++; end while (!res_valid && n < 500);
    repeat (50) @(negedge clk);
    chk("bp_start_held", eng_start, 1);
    chk("bp_done_held", eng_done, 1);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_res_data", res_data, 64'd7 << 16);
    rr_fixed = 1'b1;
    wait_idle();
    chk("bp_count", nres - n0, 2);
    lat = 40; align();
    push_op(32'd81, 1, 64'd9 << 16);
    n = 0;
    do begin @(negedge clk); n++; end while (eng_available && n < 100);
    repeat (5) @(negedge clk);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("mid_rst_start", eng_start, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
    q.delete();
    @(negedge clk); @(negedge clk) rstn = 1'b1;
    lat = 10; align(); n0 = nres;
    push_op(32'd100, 1, 64'd10 << 16);
    wait_idle();
    chk("post_rst_count", nres - n0, 1);
    lat_rand = 1; rr_rand = 1; align(); n0 = nres;
    for (int i = 0; i < 30; i++) begin
      logic [31:0] x;
      x = i == 0 ? 32'd0 : i == 1 ? 32'hFFFF_FFFF : $urandom;
      repeat ($urandom_range(0, 3)) align();
      push_op(x, 1, fx_sqrt(x));
    end
    rr_rand = 0; rr_fixed = 1'b1;
    wait_idle();
    chk("rand_count", nres - n0, 30);
`ifdef SQRT_MASTER_TIMEOUT_EN
    lat_rand = 0; lat = 3; never_done = 1; align(); n0 = nres;
    push_op(32'd7, 0, '0);
    n = 0;
    do begin @(negedge clk); n++; end while (!eng_start && n < 100);
    n = 0;
    do begin @(negedge clk); n++; end while (!err_timeout && n < 200);
    chk("tmo_cycles", n, 15);
    chk("tmo_start_low", eng_start, 0);
    chk("tmo_no_result", res_valid, 0);
    never_done = 0;
    wait_idle();
    chk("tmo_discard", nres - n0, 0);
    align();
    push_op(32'd4, 1, 64'd2 << 16);
    wait_idle();
    chk("tmo_sticky", err_timeout, 1);
    chk("tmo_next_count", nres - n0, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
